// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Frames UART RX bytes into register read/write commands, issues
//            one-cycle bus strobes and returns one response byte to UART TX.
// Option   : UART_CMD_CHKSUM_EN adds a trailing XOR check byte to each frame.
// Revision : 1.0 - initial release
//==============================================================================
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 2610,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_En,
  output logic       o_Rd_En,
  output logic [7:0] o_Addr,
  output logic [7:0] o_Wr_Data,
  input  logic [7:0] i_Rd_Data,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Done,
  output logic       o_Busy,
  output logic       o_Err,
  output logic [7:0] o_Err_Count
);

  localparam logic [7:0]  c_CMD_WR   = 8'h57;
  localparam logic [7:0]  c_CMD_RD   = 8'h52;
  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CLKS - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_CMD  = 4'd1,
    S_GET_ADDR = 4'd2,
    S_GET_DATA = 4'd3,
    S_GET_CHK  = 4'd4,
    S_EXEC     = 4'd5,
    S_RD_CAP   = 4'd6,
    S_RESP     = 4'd7,
    S_WAIT_TX  = 4'd8
  } state_t;

  // State entered once the last payload byte (ADDR or DATA) has arrived
`ifdef UART_CMD_CHKSUM_EN
  localparam state_t c_BODY_DONE = S_GET_CHK;
`else
  localparam state_t c_BODY_DONE = S_EXEC;
`endif

  state_t      r_state;
  logic [7:0]  r_cmd;
  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic [7:0]  r_resp;
  logic        r_rd_resp;
  logic [15:0] r_tmo;
  logic        r_wr_en;
  logic        r_rd_en;
  logic [7:0]  r_bus_addr;
  logic [7:0]  r_bus_data;
  logic        r_tx_dv;
  logic [7:0]  r_tx_byte;
  logic        r_err;
  logic [7:0]  r_err_count;

  logic w_in_frame;
  logic w_tmo_expire;
  logic w_chk_bad;
  logic w_cmd_bad;
  logic w_err_event;

  assign w_in_frame   = (r_state == S_GET_CMD) || (r_state == S_GET_ADDR) ||
                        (r_state == S_GET_DATA) || (r_state == S_GET_CHK);
  assign w_tmo_expire = w_in_frame && !i_Rx_DV && (r_tmo == c_TMO_LAST);

`ifdef UART_CMD_CHKSUM_EN
  assign w_chk_bad = (r_state == S_GET_CHK) && i_Rx_DV &&
                     (i_Rx_Byte != (r_cmd ^ r_addr ^ ((r_cmd == c_CMD_WR) ? r_data : 8'h00)));
`else
  assign w_chk_bad = 1'b0;
`endif

  assign w_cmd_bad   = (r_state == S_EXEC) && (r_cmd != c_CMD_WR) && (r_cmd != c_CMD_RD);
  assign w_err_event = w_tmo_expire || w_chk_bad || w_cmd_bad;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state     <= S_IDLE;
      r_cmd       <= 8'h00;
      r_addr      <= 8'h00;
      r_data      <= 8'h00;
      r_resp      <= 8'h00;
      r_rd_resp   <= 1'b0;
      r_tmo       <= 16'h0000;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_bus_addr  <= 8'h00;
      r_bus_data  <= 8'h00;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_err       <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_tx_dv <= 1'b0;
      r_err   <= w_err_event;
      if (w_err_event && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;

      // Inter-byte timer: cleared by any accepted byte, on expiry and outside frames
      if (w_in_frame && !i_Rx_DV && !w_tmo_expire)
        r_tmo <= r_tmo + 16'd1;
      else
        r_tmo <= 16'h0000;

      case (r_state)
        S_IDLE: begin
          if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE))
            r_state <= S_GET_CMD;
        end
        S_GET_CMD: begin
          if (i_Rx_DV) begin
            r_cmd   <= i_Rx_Byte;
            r_state <= S_GET_ADDR;
          end else if (w_tmo_expire) begin
            r_state <= S_IDLE;
          end
        end
        S_GET_ADDR: begin
          if (i_Rx_DV) begin
            r_addr  <= i_Rx_Byte;
            r_state <= (r_cmd == c_CMD_WR) ? S_GET_DATA : c_BODY_DONE;
          end else if (w_tmo_expire) begin
            r_state <= S_IDLE;
          end
        end
        S_GET_DATA: begin
          if (i_Rx_DV) begin
            r_data  <= i_Rx_Byte;
            r_state <= c_BODY_DONE;
          end else if (w_tmo_expire) begin
            r_state <= S_IDLE;
          end
        end
`ifdef UART_CMD_CHKSUM_EN
        S_GET_CHK: begin
          if (i_Rx_DV) begin
            r_resp    <= NAK_BYTE;
            r_rd_resp <= 1'b0;
            r_state   <= w_chk_bad ? S_RESP : S_EXEC;
          end else if (w_tmo_expire) begin
            r_state <= S_IDLE;
          end
        end
`endif
        S_EXEC: begin
          r_rd_resp <= 1'b0;
          if (r_cmd == c_CMD_WR) begin
            r_wr_en    <= 1'b1;
            r_bus_addr <= r_addr;
            r_bus_data <= r_data;
            r_resp     <= ACK_BYTE;
            r_state    <= S_RESP;
          end else if (r_cmd == c_CMD_RD) begin
            r_rd_en    <= 1'b1;
            r_bus_addr <= r_addr;
            r_rd_resp  <= 1'b1;
            r_state    <= S_RD_CAP;
          end else begin
            r_resp  <= NAK_BYTE;
            r_state <= S_RESP;
          end
        end
        S_RD_CAP: begin
          r_state <= S_RESP;
        end
        // Read data arrives the cycle after the strobe, i.e. during RESP
        S_RESP: begin
          r_tx_dv   <= 1'b1;
          r_tx_byte <= r_rd_resp ? i_Rd_Data : r_resp;
          r_state   <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (i_Tx_Done && !r_tx_dv)
            r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Wr_En     = r_wr_en;
  assign o_Rd_En     = r_rd_en;
  assign o_Addr      = r_bus_addr;
  assign o_Wr_Data   = r_bus_data;
  assign o_Tx_DV     = r_tx_dv;
  assign o_Tx_Byte   = r_tx_byte;
  assign o_Busy      = (r_state != S_IDLE);
  assign o_Err       = r_err;
  assign o_Err_Count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_cmd_ctrl
// Purpose  : Randomized self-checking bench for uart_cmd_ctrl against a
//            frame-level reference model (honours UART_CMD_CHKSUM_EN).
// Revision : 1.0 - initial release
//==============================================================================
module tb_uart_cmd_ctrl;

  localparam logic [7:0] c_SYNC = 8'hA5;
  localparam logic [7:0] c_ACK  = 8'h06;
  localparam logic [7:0] c_NAK  = 8'h15;
  localparam logic [7:0] c_WR   = 8'h57;
  localparam logic [7:0] c_RD   = 8'h52;
  localparam int         c_TMO  = 2610;
`ifdef UART_CMD_CHKSUM_EN
  localparam bit c_CHK_EN = 1'b1;
`else
  localparam bit c_CHK_EN = 1'b0;
`endif

  logic       i_Clock   = 1'b0;
  logic       i_Reset   = 1'b1;
  logic       i_Rx_DV   = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic [7:0] i_Rd_Data = 8'h00;
  logic       i_Tx_Done = 1'b0;
  logic       o_Wr_En, o_Rd_En, o_Tx_DV, o_Busy, o_Err;
  logic [7:0] o_Addr, o_Wr_Data, o_Tx_Byte, o_Err_Count;

  uart_cmd_ctrl dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Wr_En(o_Wr_En), .o_Rd_En(o_Rd_En), .o_Addr(o_Addr), .o_Wr_Data(o_Wr_Data),
    .i_Rd_Data(i_Rd_Data), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Done(i_Tx_Done), .o_Busy(o_Busy), .o_Err(o_Err), .o_Err_Count(o_Err_Count)
  );

  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_errs = 0;
  int last_dv = 0;
  logic [7:0] mem [256];
  logic [7:0] rd_v;

  int         wr_cyc[$];
  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         rd_cyc[$];
  logic [7:0] rd_addr[$];
  int         tx_cyc[$];
  logic [7:0] tx_byte[$];
  int         err_cyc[$];

  // Event recorder, sampled mid-cycle
  always @(negedge i_Clock) begin
    if (o_Wr_En) begin wr_cyc.push_back(cyc); wr_addr.push_back(o_Addr); wr_data.push_back(o_Wr_Data); end
    if (o_Rd_En) begin rd_cyc.push_back(cyc); rd_addr.push_back(o_Addr); end
    if (o_Tx_DV) begin tx_cyc.push_back(cyc); tx_byte.push_back(o_Tx_Byte); end
    if (o_Err)   err_cyc.push_back(cyc);
  end

  // Register-bus slave: data valid only in the cycle after the read strobe
  initial forever begin
    @(negedge i_Clock);
    if (o_Rd_En) begin
      rd_v = mem[o_Addr];
      @(posedge i_Clock); #1 i_Rd_Data = rd_v;
      @(posedge i_Clock); #1 i_Rd_Data = 8'($urandom);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_Clock); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_Rx_DV = 1'b1; i_Rx_Byte = b; last_dv = cyc;
    tick(1);
    i_Rx_DV = 1'b0; i_Rx_Byte = 8'($urandom);
    tick(gap);
  endtask

  task automatic clear_q();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); rd_cyc.delete(); rd_addr.delete();
    tx_cyc.delete(); tx_byte.delete(); err_cyc.delete();
  endtask

  task automatic bump_err();
    if (exp_errs < 255) exp_errs++;
  endtask

  task automatic check_zero_outs(input string tag);
    check_val(tag, {o_Wr_En, o_Rd_En, o_Addr, o_Wr_Data, o_Tx_DV, o_Tx_Byte, o_Busy, o_Err, o_Err_Count}, 0);
  endtask

  // One frame through the DUT; expectations derived from the frame rules only.
  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                          input bit bad, input int stall_idx, input int stall_len, input bit early_done);
    logic [7:0] q[$];
    logic [7:0] x;
    bit tmo;
    int kind; // 0 write, 1 read, 2 nak
    int t;
    q.push_back(c_SYNC); q.push_back(cmd); q.push_back(addr);
    if (cmd == c_WR) q.push_back(data);
    if (c_CHK_EN) begin
      x = cmd ^ addr ^ ((cmd == c_WR) ? data : 8'h00);
      if (bad) x = x ^ 8'(1 + $urandom_range(0, 254));
      q.push_back(x);
    end
    tmo  = (stall_idx >= 0) && (stall_idx < int'(q.size()) - 1) && (stall_len >= c_TMO);
    kind = (c_CHK_EN && bad) ? 2 : (cmd == c_WR) ? 0 : (cmd == c_RD) ? 1 : 2;
    clear_q();
    for (int i = 0; i < int'(q.size()); i++) begin
      if (i == stall_idx) begin
        send_byte(q[i], stall_len);
        if (tmo) break;
      end else begin
        send_byte(q[i], (i == int'(q.size()) - 1) ? 0 : $urandom_range(0, 3));
      end
    end
    if (tmo) begin
      tick(3);
      bump_err();
      check_val("tmo_err_pulses", err_cyc.size(), 1);
      check_val("tmo_no_tx", tx_cyc.size(), 0);
      check_val("tmo_no_strobe", wr_cyc.size() + rd_cyc.size(), 0);
      check_val("tmo_busy", o_Busy, 0);
      check_val("tmo_err_count", o_Err_Count, exp_errs);
      return;
    end
    t = last_dv;
    if (early_done) begin
      tick(2);
      i_Tx_Done = 1'b1;
      tick(1);
      i_Tx_Done = 1'b0;
      check_val("done_with_txdv_ignored", o_Busy, 1);
    end
    for (int k = 0; k < 20 && tx_cyc.size() == 0; k++) tick(1);
    tick(1);
    if ($urandom_range(0, 1) == 1) send_byte(($urandom_range(0, 1) == 1) ? c_SYNC : 8'($urandom), 0);
    tick($urandom_range(0, 3));
    i_Tx_Done = 1'b1;
    tick(1);
    i_Tx_Done = 1'b0;
    check_val("busy_after_done", o_Busy, 0);
    check_val("tx_count", tx_cyc.size(), 1);
    if (kind == 0) begin
      check_val("wr_count", wr_cyc.size(), 1);
      check_val("rd_count_on_wr", rd_cyc.size(), 0);
      if (wr_cyc.size() > 0) begin
        check_val("wr_latency", wr_cyc[0] - t, 2);
        check_val("wr_addr", wr_addr[0], addr);
        check_val("wr_data", wr_data[0], data);
      end
      if (tx_cyc.size() > 0) begin
        check_val("wr_tx_latency", tx_cyc[0] - t, 3);
        check_val("wr_tx_byte", tx_byte[0], c_ACK);
      end
      check_val("wr_no_err", err_cyc.size(), 0);
      mem[addr] = data;
    end else if (kind == 1) begin
      check_val("rd_count", rd_cyc.size(), 1);
      check_val("wr_count_on_rd", wr_cyc.size(), 0);
      if (rd_cyc.size() > 0) begin
        check_val("rd_latency", rd_cyc[0] - t, 2);
        check_val("rd_addr", rd_addr[0], addr);
      end
      if (tx_cyc.size() > 0) begin
        check_val("rd_tx_latency", tx_cyc[0] - t, 4);
        check_val("rd_tx_byte", tx_byte[0], mem[addr]);
      end
      check_val("rd_no_err", err_cyc.size(), 0);
    end else begin
      bump_err();
      check_val("nak_no_strobe", wr_cyc.size() + rd_cyc.size(), 0);
      if (tx_cyc.size() > 0) check_val("nak_tx_byte", tx_byte[0], c_NAK);
      check_val("nak_err_pulses", err_cyc.size(), 1);
    end
    check_val("err_count", o_Err_Count, exp_errs);
  endtask

  function automatic logic [7:0] rand_cmd();
    logic [7:0] c;
    case ($urandom_range(0, 4))
      0, 1:    c = c_WR;
      2, 3:    c = c_RD;
      default: begin
        c = 8'($urandom);
        if (c == c_WR || c == c_RD) c = 8'h00;
      end
    endcase
    return c;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    tick(3);
    check_zero_outs("reset_outputs");
    i_Reset = 1'b0;
    tick(1);
    check_zero_outs("after_reset_idle");

    // Directed: write with TX_DONE coincident with TX_DV, then read
    do_frame(8'h57, 8'h10, 8'h3C, 1'b0, -1, 0, 1'b1);
    mem[8'h20] = 8'hC3;
    do_frame(8'h52, 8'h20, 8'h00, 1'b0, -1, 0, 1'b0);
    // Bad checksum, or unknown command when no check byte exists
    if (c_CHK_EN) do_frame(8'h57, 8'h10, 8'h3C, 1'b1, -1, 0, 1'b0);
    else          do_frame(8'h41, 8'h10, 8'h3C, 1'b0, -1, 0, 1'b0);
    check_val("err_count_first", o_Err_Count, 1);

    // Timeout after CMD, then normal write; then a stall that lands on the expiry cycle
    do_frame(8'h57, 8'h11, 8'h22, 1'b0, 1, c_TMO, 1'b0);
    do_frame(8'h57, 8'h33, 8'h44, 1'b0, -1, 0, 1'b0);
    do_frame(8'h57, 8'h55, 8'h66, 1'b0, 2, c_TMO - 1, 1'b0);
    do_frame(8'h52, 8'h77, 8'h00, 1'b0, 0, c_TMO - 1, 1'b0);
    do_frame(8'h52, 8'h78, 8'h00, 1'b0, 0, c_TMO, 1'b0);

    // Junk in IDLE is ignored
    clear_q();
    send_byte(8'h00, 1); send_byte(8'hFF, 0); send_byte(8'hA4, 2);
    check_val("junk_busy", o_Busy, 0);
    check_val("junk_no_err", err_cyc.size(), 0);
    do_frame(8'h41, 8'h00, 8'h00, 1'b0, -1, 0, 1'b0);

    // Randomized frames with IDLE noise
    for (int n = 0; n < 150; n++) begin
      logic [7:0] j;
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom);
        if (j == c_SYNC) j = 8'h5A;
        send_byte(j, $urandom_range(0, 2));
      end
      do_frame(rand_cmd(), 8'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0), -1, 0, 1'b0);
    end

    // Error counter saturation
    for (int n = 0; n < 300; n++) begin
      if (c_CHK_EN) do_frame(($urandom_range(0, 1) == 1) ? c_WR : c_RD, 8'($urandom), 8'($urandom), 1'b1, -1, 0, 1'b0);
      else          do_frame(8'h41, 8'($urandom), 8'h00, 1'b0, -1, 0, 1'b0);
    end
    check_val("err_count_saturated", o_Err_Count, 8'hFF);

    // Reset mid-frame abandons it
    clear_q();
    send_byte(c_SYNC, 0); send_byte(8'h57, 1); send_byte(8'h10, 0);
    i_Reset = 1'b1;
    tick(1);
    check_zero_outs("reset_mid_frame");
    i_Reset = 1'b0;
    exp_errs = 0;
    send_byte(8'h3C, 0); send_byte(8'h6B, 4);
    check_val("reset_no_wr", wr_cyc.size(), 0);
    check_val("reset_no_tx", tx_cyc.size(), 0);
    check_val("reset_busy", o_Busy, 0);
    do_frame(8'h57, 8'h10, 8'h3C, 1'b0, -1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
